// File: rtl/iecdrv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iecdrv_pkg
// Purpose  : Shared types and round-robin helper for the SD block arbiter.
// Revision : 1.0
// ============================================================================
package iecdrv_pkg;

  localparam int LBA_W   = 32;
  localparam int MAX_DRV = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    GAP  = 2'd3
  } state_t;

  // First pending index after 'last', wrapping modulo num; returns last if none.
  function automatic logic [1:0] rr_pick(input logic [MAX_DRV-1:0] pend,
                                         input logic [1:0]         last,
                                         input int                 num);
    logic [1:0] pick;
    logic       found;
    int         idx;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= MAX_DRV; k++) begin
      if (k <= num) begin
        idx = (int'(last) + k) % num;
        if (!found && pend[idx[1:0]]) begin
          pick  = idx[1:0];
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/iecdrv_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : iecdrv_rr_pick
// Purpose  : Combinational round-robin priority encoder over NUM_DRV requests.
// Revision : 1.0
// ============================================================================
module iecdrv_rr_pick
  import iecdrv_pkg::*;
#(
  parameter int NUM_DRV = 2,
  parameter int SEL_W   = 2
) (
  input  logic [NUM_DRV-1:0] pend,
  input  logic [SEL_W-1:0]   last,
  output logic [SEL_W-1:0]   pick,
  output logic               any_pend
);

  logic [MAX_DRV-1:0] pend_ext;
  logic [1:0]         last_ext;
  logic [1:0]         pick_raw;

  always_comb begin
    pend_ext                = '0;
    pend_ext[NUM_DRV-1:0]   = pend;
    last_ext                = 2'(last);
    pick_raw                = rr_pick(pend_ext, last_ext, NUM_DRV);
    pick                    = SEL_W'(pick_raw);
    any_pend                = |pend;
  end

endmodule
`default_nettype wire

// File: rtl/iecdrv_sd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : iecdrv_sd_arbiter
// Purpose  : Round-robin sharing of one SD block port among NUM_DRV loaders.
// Revision : 1.0
// ============================================================================
module iecdrv_sd_arbiter
  import iecdrv_pkg::*;
#(
  parameter int NUM_DRV = 2,
  parameter int SEL_W   = 2,
  parameter int TO_W    = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LBA_W*NUM_DRV-1:0] req_lba,
  input  logic [NUM_DRV-1:0]       req_rd,
  input  logic [NUM_DRV-1:0]       req_wr,
  output logic [NUM_DRV-1:0]       req_ack,
  output logic [NUM_DRV-1:0]       req_err,
  output logic [LBA_W-1:0]         sd_lba,
  output logic                     sd_rd,
  output logic                     sd_wr,
  input  logic                     sd_ack,
  output logic [SEL_W-1:0]         sd_sel,
  output logic                     busy
);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d, last_q, last_d, pick;
  logic [LBA_W-1:0]   lba_q, lba_d, lba_pick;
  logic               rd_q, rd_d, wr_q, wr_d;
  logic [NUM_DRV-1:0] ack_q, ack_d, err_q, err_d;
  logic [NUM_DRV-1:0] pend, pick_oh, sel_oh;
  logic [TO_W-1:0]    to_q, to_d, to_inc;
  logic               ack_prev_q;
  logic               any_pend;

  assign pend = req_rd | req_wr;

  iecdrv_rr_pick #(
    .NUM_DRV (NUM_DRV),
    .SEL_W   (SEL_W)
  ) u_rr_pick (
    .pend     (pend),
    .last     (last_q),
    .pick     (pick),
    .any_pend (any_pend)
  );

  // One-hot forms of the candidate and current grant avoid width-mismatched indexing.
  always_comb begin
    pick_oh  = '0;
    sel_oh   = '0;
    lba_pick = '0;
    for (int i = 0; i < NUM_DRV; i++) begin
      if (pick == SEL_W'(i)) begin
        pick_oh[i] = 1'b1;
        lba_pick   = req_lba[LBA_W*i +: LBA_W];
      end
      if (sel_q == SEL_W'(i)) sel_oh[i] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    lba_d   = lba_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    ack_d   = '0;
    err_d   = '0;
    to_d    = to_q;
    to_inc  = to_q + TO_W'(1);
    case (state_q)
      IDLE: begin
        if (any_pend) begin
          sel_d   = pick;
          last_d  = pick;
          lba_d   = lba_pick;
          wr_d    = |(req_wr & pick_oh);
          rd_d    = ~(|(req_wr & pick_oh));
          to_d    = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (sd_ack) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          ack_d   = sel_oh;
          state_d = XFER;
        end else begin
          to_d = to_inc;
          if (&to_inc) begin
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            err_d   = sel_oh;
            state_d = GAP;
          end
        end
      end
      XFER: begin
        ack_d = sd_ack ? sel_oh : '0;
        if (ack_prev_q && !sd_ack) state_d = GAP;
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      last_q     <= SEL_W'(NUM_DRV - 1);
      lba_q      <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      ack_q      <= '0;
      err_q      <= '0;
      to_q       <= '0;
      ack_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      lba_q      <= lba_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      to_q       <= to_d;
      ack_prev_q <= sd_ack;
    end
  end

  assign req_ack = ack_q;
  assign req_err = err_q;
  assign sd_lba  = lba_q;
  assign sd_rd   = rd_q;
  assign sd_wr   = wr_q;
  assign sd_sel  = sel_q;
  assign busy    = (state_q != IDLE);

endmodule
`default_nettype wire
